// File: rtl/memory_access_pkg.sv
// Shared encodings and lane helpers for the memory-access stage.
package memory_access_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } mem_state_t;

  // Stores only know signed sizes; unsigned variants are load-only.
  function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
    case (f3)
      F3_B, F3_H, F3_W: f3_legal = 1'b1;
      F3_BU, F3_HU:     f3_legal = !is_store;
      default:          f3_legal = 1'b0;
    endcase
  endfunction

  function automatic logic addr_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'b01:   addr_misaligned = lo[0];
      2'b10:   addr_misaligned = (lo != 2'b00);
      default: addr_misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'b00:   byte_en = 4'b0001 << lo;
      2'b01:   byte_en = 4'b0011 << {lo[1], 1'b0};
      default: byte_en = 4'b1111;
    endcase
  endfunction

  // Replicate the store operand so every enabled lane carries the right bytes.
  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   store_lanes = {4{d[7:0]}};
      2'b01:   store_lanes = {2{d[15:0]}};
      default: store_lanes = d;
    endcase
  endfunction

endpackage

// File: rtl/memory_access_load_align.sv
// Selects the addressed byte/halfword from a read word and extends it.
module load_align
  import memory_access_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [31:0] shifted;

  assign shifted = rdata >> {addr_lo, 3'b000};

  // Lane select and sign/zero extension by access type.
  always_comb begin
    result = rdata;
    case (funct3)
      F3_B:    result = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   result = {24'h000000, shifted[7:0]};
      F3_H:    result = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   result = {16'h0000, shifted[15:0]};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// Memory-access pipeline stage: issues data-memory requests for loads and
// stores, stalls upstream while a request is outstanding, and registers the
// writeback-stage inputs.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | accepting instructions; non-memory ops pass through
// ST_REQ  | dmem_req_o held with captured op until dmem_gnt_i
// ST_WAIT | load granted, waiting for dmem_rvalid_i or timeout
module memory_access
  import memory_access_pkg::*;
#(
  parameter int RESP_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_i,
  input  logic [4:0]  sel_rd_i,
  input  logic        mem_re_i,
  input  logic        mem_we_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] store_data_i,
  output logic        stall_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic [4:0]  sel_rd_o,
  output logic        mem_re_o,
  output logic        mem_we_o,
  output logic [31:0] alu_result_o,
  output logic [31:0] data_o,
  output logic        misaligned_o,
  output logic        bus_err_o
);

  localparam int CW = (RESP_TIMEOUT < 2) ? 1 : $clog2(RESP_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(RESP_TIMEOUT - 1);

  mem_state_t state_q, state_d;

  logic [4:0]    op_rd_q;
  logic [31:0]   op_addr_q;
  logic [2:0]    op_f3_q;
  logic          op_we_q;
  logic [3:0]    op_be_q;
  logic [31:0]   op_wdata_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          capture;

  logic [4:0]  wb_rd_d;
  logic        wb_re_d, wb_we_d, mis_d, berr_d;
  logic [31:0] wb_alu_d, wb_data_d;

  logic        is_mem_op, access_ok;
  logic [31:0] load_data;

  assign is_mem_op = mem_re_i | mem_we_i;
  assign access_ok = f3_legal(funct3_i, mem_we_i) &&
                     !addr_misaligned(funct3_i, alu_result_i[1:0]);

  load_align u_load_align (
    .rdata   (dmem_rdata_i),
    .addr_lo (op_addr_q[1:0]),
    .funct3  (op_f3_q),
    .result  (load_data)
  );

  assign dmem_addr_o  = {op_addr_q[31:2], 2'b00};
  assign dmem_be_o    = op_be_q;
  assign dmem_wdata_o = op_wdata_q;
  assign dmem_we_o    = dmem_req_o & op_we_q;

  // Next state, bus handshake, stall and next writeback values; bubble by default.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    capture    = 1'b0;
    stall_o    = 1'b0;
    dmem_req_o = 1'b0;
    wb_rd_d    = 5'd0;
    wb_re_d    = 1'b0;
    wb_we_d    = 1'b0;
    wb_alu_d   = 32'h0;
    wb_data_d  = 32'h0;
    mis_d      = 1'b0;
    berr_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (valid_i) begin
          if (!is_mem_op) begin
            wb_rd_d  = sel_rd_i;
            wb_alu_d = alu_result_i;
          end else if (access_ok) begin
            capture = 1'b1;
            stall_o = 1'b1;
            state_d = ST_REQ;
          end else begin
            mis_d = 1'b1;
          end
        end
      end
      ST_REQ: begin
        dmem_req_o = 1'b1;
        stall_o    = 1'b1;
        if (dmem_gnt_i) begin
          if (op_we_q) begin
            stall_o  = 1'b0;
            wb_we_d  = 1'b1;
            wb_alu_d = op_addr_q;
            state_d  = ST_IDLE;
          end else begin
            cnt_d   = '0;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        stall_o = 1'b1;
        if (dmem_rvalid_i) begin
          stall_o   = 1'b0;
          wb_rd_d   = op_rd_q;
          wb_re_d   = 1'b1;
          wb_alu_d  = op_addr_q;
          wb_data_d = load_data;
          state_d   = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          stall_o = 1'b0;
          berr_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, timeout counter and captured memory operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      op_rd_q    <= 5'd0;
      op_addr_q  <= 32'h0;
      op_f3_q    <= 3'b000;
      op_we_q    <= 1'b0;
      op_be_q    <= 4'b0000;
      op_wdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        op_rd_q    <= sel_rd_i;
        op_addr_q  <= alu_result_i;
        op_f3_q    <= funct3_i;
        op_we_q    <= mem_we_i;
        op_be_q    <= byte_en(funct3_i, alu_result_i[1:0]);
        op_wdata_q <= store_lanes(funct3_i, store_data_i);
      end
    end
  end

  // Writeback-stage registers and exception pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_rd_o     <= 5'd0;
      mem_re_o     <= 1'b0;
      mem_we_o     <= 1'b0;
      alu_result_o <= 32'h0;
      data_o       <= 32'h0;
      misaligned_o <= 1'b0;
      bus_err_o    <= 1'b0;
    end else begin
      sel_rd_o     <= wb_rd_d;
      mem_re_o     <= wb_re_d;
      mem_we_o     <= wb_we_d;
      alu_result_o <= wb_alu_d;
      data_o       <= wb_data_d;
      misaligned_o <= mis_d;
      bus_err_o    <= berr_d;
    end
  end

endmodule

// File: doc/memory_access.md
MEMORY_ACCESS -- requirements
Module: memory_access

Interface
REQ-001 Parameter: RESP_TIMEOUT, default 255, max cycles spent in WAIT for dmem_rvalid_i before a bus error is raised.
REQ-002 clk  input  1  single clock for the block; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 valid_i  input  1  execute stage presents an instruction this cycle.
REQ-005 sel_rd_i  input  5  destination register index.
REQ-006 mem_re_i / mem_we_i  input  1 each  load / store instruction; never both high.
REQ-007 funct3_i  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 alu_result_i  input  32  ALU result; byte address for memory ops.
REQ-009 store_data_i  input  32  rs2 value for stores.
REQ-010 stall_o  output  1  hold the upstream stage; combinational.
REQ-011 dmem_req_o, dmem_we_o  output  1 each  memory request and write enable.
REQ-012 dmem_be_o  output  4  byte enables; dmem_addr_o  output  32  word-aligned address; dmem_wdata_o  output  32  lane-replicated store data.
REQ-013 dmem_gnt_i, dmem_rvalid_i  input  1 each  request accepted / read data valid; dmem_rdata_i  input  32  read word.
REQ-014 sel_rd_o  output  5; mem_re_o, mem_we_o  output  1 each; alu_result_o, data_o  output  32 each: registered writeback-stage inputs.
REQ-015 misaligned_o, bus_err_o  output  1 each  single-cycle registered exception pulses.

Function
REQ-016 FSM states IDLE, REQ, WAIT; reset state IDLE.
REQ-017 IDLE, valid_i, no memory op: next edge registers sel_rd_i, alu_result_i, mem_re_o=mem_we_o=0, data_o=0; latency 1, no stall.
REQ-018 IDLE, valid_i, memory op, aligned, legal funct3: capture op fields internally, stall_o=1, go to REQ.
REQ-019 Misaligned (H with addr[0]=1; W with addr[1:0]!=0) or illegal funct3: no request, misaligned_o=1 for one cycle, bubble to writeback, stay IDLE, no stall.
REQ-020 Bubble = sel_rd_o=0, mem_re_o=0, mem_we_o=0, so writeback harmlessly targets x0; bubble driven in every cycle no instruction completes, including while !valid_i.
REQ-021 REQ: dmem_req_o=1 held with stable addr/be/wdata/we until dmem_gnt_i; stall_o=1 except as in REQ-022.
REQ-022 Store completes on the gnt cycle: stall_o=0 that cycle, next edge retires (sel_rd_o=0, mem_we_o=1), return to IDLE.
REQ-023 Load on gnt: go to WAIT, counter cleared; dmem_rvalid_i in the gnt cycle is ignored.
REQ-024 WAIT: on dmem_rvalid_i, stall_o=0; next edge data_o = aligned/extended rdata, mem_re_o=1, sel_rd_o and alu_result_o from captured op; return to IDLE.
REQ-025 WAIT counter reaching RESP_TIMEOUT without rvalid: bus_err_o pulse, bubble, release stall, IDLE.
REQ-026 Byte lanes from addr[1:0]: B be=0001<<addr[1:0], H be=0011<<{addr[1],0}, W be=1111; wdata replicates the byte (x4) or halfword (x2).
REQ-027 Loads: B/H sign-extend, BU/HU zero-extend the selected lane; W passes through.

Reset
REQ-028 rst_n low at any time, including mid-REQ/WAIT, forces IDLE, dmem_req_o=0, all registered outputs 0, counter 0; the pending operation is abandoned.
REQ-029 After rst_n deasserts, the first accepted instruction behaves as from IDLE.

Structure
REQ-030 Shared constants package holds funct3 load/store encodings and the mem_state_t enum.
REQ-031 Lane extraction/extension is a combinational sub-module load_align (rdata, addr[1:0], funct3 -> 32-bit result).

Verification
REQ-032 ADD rd=5, alu_result=0x1234 -> next cycle sel_rd_o=5, alu_result_o=0x1234, mem_re_o=0, stall_o never high.
REQ-033 LB addr 0x103, gnt after 2 cycles, rvalid 1 cycle later with rdata 0x80FFFFFF -> data_o=0xFFFFFF80, be=1000, addr 0x100, stall high until rvalid cycle.
REQ-034 SH addr 0x202, store_data 0x0000ABCD, gnt immediate -> be=1100, wdata 0xABCDABCD, we=1, mem_we_o=1 and sel_rd_o=0 next cycle.
REQ-035 LW addr 0x6 -> misaligned_o pulses one cycle, dmem_req_o stays 0, bubble output.
REQ-036 LHU, gnt, no rvalid for RESP_TIMEOUT cycles -> bus_err_o pulses, stall released, FSM IDLE.
REQ-037 rst_n low while in WAIT -> dmem_req_o=0, outputs 0, FSM IDLE; later rvalid ignored.
